// File: rtl/wide_add_pkg.sv
// Shared types and carry-lookahead helpers for the multi-precision add/subtract sequencer.
package wide_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wide_add_state_e;

  typedef struct packed {
    logic gen;
    logic prop;
  } group_gp_t;

  // Group generate/propagate of a 4-bit block; independent of the block's carry-in.
  function automatic group_gp_t cla_group_gp(input logic [3:0] g, input logic [3:0] p);
    group_gp_t r;
    r.gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.prop = &p;
    return r;
  endfunction

  // Carry into each bit of a 4-bit block, all computed directly from the block carry-in.
  function automatic logic [3:0] cla_carries(input logic [3:0] g, input logic [3:0] p,
                                             input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/adder_16_cin.sv
// Combinational 16-bit two-level carry-lookahead adder: four 4-bit groups under a
// second lookahead level. Also exposes the carry into bit 15 for signed overflow.
module adder_16_cin
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout,
  output logic              c15
);

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] c;
  logic [3:0]        grp_g;
  logic [3:0]        grp_p;
  logic [4:0]        grp_c;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_group
    group_gp_t gp_k;
    assign gp_k               = cla_group_gp(g[4*k +: 4], p[4*k +: 4]);
    assign grp_g[k]           = gp_k.gen;
    assign grp_p[k]           = gp_k.prop;
    assign c[4*k +: 4]        = cla_carries(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
  end

  // Second-level lookahead: every group carry is a flat function of cin, never rippled.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign s    = p ^ c;
  assign cout = grp_c[4];
  assign c15  = c[15];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams LS-first word pairs through one 16-bit
// CLA slice with a registered inter-word carry. Define WIDE_ADD_OVF_EN to add out_ovf.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int MAX_WORDS = 8,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_carry,
`ifdef WIDE_ADD_OVF_EN
  output logic              out_ovf,
`endif
  output logic              busy
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  wide_add_state_e   state;
  logic              sub;
  logic              carry;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_clamped;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              cout;
  logic              c15;
  logic              in_fire;
  logic              out_fire;
  logic              last_word;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign in_ready    = (state == RUN) && (!out_valid || out_ready);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_word   = (remaining == ONE_LEN);
  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  // Subtraction is A + ~B + 1: the +1 comes from the carry register seeded with sub.
  assign b_eff = sub ? ~in_b : in_b;

  adder_16_cin u_slice (
    .a    (in_a),
    .b    (b_eff),
    .cin  (carry),
    .s    (sum),
    .cout (cout),
    .c15  (c15)
  );

`ifndef WIDE_ADD_OVF_EN
  logic unused_c15;
  assign unused_c15 = c15;
`endif

  // NOTE: state and outputs share one clocked block with non-blocking assignments, so every
  // branch reads pre-edge values and ordering inside the block cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sub       <= 1'b0;
      carry     <= 1'b0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A zero-length command is consumed here without leaving IDLE.
          if (cmd_valid && (cmd_len != '0)) begin
            sub       <= cmd_sub;
            carry     <= cmd_sub;
            remaining <= len_clamped;
            state     <= RUN;
          end
        end

        RUN: begin
          if (in_fire) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_carry <= cout;
            out_last  <= last_word;
`ifdef WIDE_ADD_OVF_EN
            out_ovf   <= last_word & (c15 ^ cout);
`endif
            carry     <= cout;
            remaining <= remaining - ONE_LEN;
            if (last_word) begin
              state <= DRAIN;
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end

        DRAIN: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed cases plus randomized commands
// checked against a full-width arithmetic reference model.
module tb_wide_add_sequencer;

  localparam int MAX   = 8;
  localparam int LEN_W = $clog2(MAX + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_sub;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             out_last;
  logic             out_carry;
  logic             busy;
`ifdef WIDE_ADD_OVF_EN
  logic             out_ovf;
`endif

  wide_add_sequencer #(.MAX_WORDS(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_sub   (cmd_sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
`ifdef WIDE_ADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        last;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_cycles[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [15:0] op_a[16];
  logic [15:0] op_b[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: whole-operand arithmetic; word i's carry is the carry (or no-borrow) of the
  // low (i+1) words taken as one integer.
  task automatic push_expected(input int n, input bit sub);
    logic        [143:0] av, bv, res, mask;
    logic signed [143:0] sa, sb, sr, lim, one_s;
    exp_t e;
    av = '0;
    bv = '0;
    one_s = 1;
    for (int i = 0; i < n; i++) begin
      av[16*i +: 16] = op_a[i];
      bv[16*i +: 16] = op_b[i];
    end
    res = sub ? (av - bv) : (av + bv);
    sa = $signed(av);
    sb = $signed(bv);
    if (av[16*n-1]) sa = sa - (one_s <<< (16*n));
    if (bv[16*n-1]) sb = sb - (one_s <<< (16*n));
    sr  = sub ? (sa - sb) : (sa + sb);
    lim = one_s <<< (16*n - 1);
    for (int i = 0; i < n; i++) begin
      mask    = (144'd1 << (16*(i+1))) - 144'd1;
      e.sum   = res[16*i +: 16];
      e.last  = (i == n - 1);
      e.carry = sub ? ((av & mask) >= (bv & mask))
                    : (((av & mask) + (bv & mask)) > mask);
      e.ovf   = e.last && ((sr >= lim) || (sr < -lim));
      exp_q.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare on each handshake, hold check while stalled.
  initial begin
    logic        held;
    logic [15:0] h_sum;
    logic        h_last, h_carry;
    exp_t        e;
    held = 1'b0;
    h_sum = '0;
    h_last = 1'b0;
    h_carry = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && out_valid) begin
          check("hold_sum", 32'(out_sum), 32'(h_sum));
          check("hold_last", 32'(out_last), 32'(h_last));
          check("hold_carry", 32'(out_carry), 32'(h_carry));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(out_sum), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sum", 32'(out_sum), 32'(e.sum));
            check("last", 32'(out_last), 32'(e.last));
            check("carry", 32'(out_carry), 32'(e.carry));
`ifdef WIDE_ADD_OVF_EN
            check("ovf", 32'(out_ovf), 32'(e.ovf));
`endif
          end
          hs_cycles.push_back(cyc);
          held = 1'b0;
        end else if (out_valid) begin
          held    = 1'b1;
          h_sum   = out_sum;
          h_last  = out_last;
          h_carry = out_carry;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic run_cmd(input int len, input bit sub, input int feed, input bit rand_valid,
                         input bit wait_done);
    int  n, idx, guard;
    bit  fire;
    n = (len > MAX) ? MAX : len;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_sub   = sub;
    if (n > 0) push_expected(n, sub);
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < n && idx < feed && guard < 2000) begin
      in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_a = op_a[idx];
      in_b = op_b[idx];
      #1;
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) begin
        idx++;
        check("latency", 32'(out_valid), 32'd1);
      end
      guard++;
    end
    in_valid = 1'b0;
    if (wait_done) begin
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = '0;
    cmd_sub = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_last_carry", 32'({out_last, out_carry}), 32'd0);
    rst = 1'b0;

    // Two-word add at full rate: carry chains from word 0 into word 1.
    op_a[0] = 16'hFFFF; op_b[0] = 16'h0001;
    op_a[1] = 16'h0000; op_b[1] = 16'h0000;
    hs_cycles.delete();
    run_cmd(2, 1'b0, 99, 1'b0, 1'b1);
    check("t1_words", 32'(hs_cycles.size()), 32'd2);
    if (hs_cycles.size() == 2) check("t1_rate", 32'(hs_cycles[1] - hs_cycles[0]), 32'd1);

    // Single-word subtract with borrow.
    op_a[0] = 16'h0005; op_b[0] = 16'h0007;
    run_cmd(1, 1'b1, 99, 1'b0, 1'b1);

    // Backpressure: output stalled after the first word of a three-word add.
    op_a[0] = 16'hFFFF; op_b[0] = 16'hFFFF;
    op_a[1] = 16'h8000; op_b[1] = 16'h8000;
    op_a[2] = 16'h1234; op_b[2] = 16'h0000;
    rdy_mode = 2;
    hs_cycles.delete();
    fork
      run_cmd(3, 1'b0, 99, 1'b0, 1'b1);
      begin
        g = 0;
        while (!out_valid && g < 100) begin
          @(negedge clk);
          g++;
        end
        repeat (4) begin
          @(negedge clk);
          #1;
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        rdy_mode = 0;
      end
    join
    check("bp_words", 32'(hs_cycles.size()), 32'd3);

    // Zero-length command is consumed without any activity.
    run_cmd(0, 1'b0, 99, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_out_valid", 32'(out_valid), 32'd0);
    end

    // Over-long command is clamped to MAX words.
    for (int i = 0; i < 16; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
    end
    hs_cycles.delete();
    run_cmd(MAX + 3, 1'b0, 99, 1'b0, 1'b1);
    check("clamp_words", 32'(hs_cycles.size()), 32'(MAX));

    // Reset in the middle of a four-word command drops the pending word.
    rdy_mode = 2;
    op_a[0] = 16'hFFFF; op_b[0] = 16'hFFFF;
    run_cmd(4, 1'b0, 1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    rdy_mode = 0;
    op_a[0] = 16'h0001; op_b[0] = 16'h0001;
    run_cmd(1, 1'b0, 99, 1'b0, 1'b1);

`ifdef WIDE_ADD_OVF_EN
    op_a[0] = 16'h7FFF; op_b[0] = 16'h0001;
    run_cmd(1, 1'b0, 99, 1'b0, 1'b1);
`endif

    // Randomized commands with random valid and ready patterns.
    rdy_mode = 1;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 5))
          0:       op_a[i] = 16'hFFFF;
          1:       op_a[i] = 16'h0000;
          default: op_a[i] = 16'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0:       op_b[i] = 16'hFFFF;
          1:       op_b[i] = 16'h8000;
          default: op_b[i] = 16'($urandom);
        endcase
      end
      run_cmd(int'($urandom_range(0, MAX + 3)), 1'($urandom_range(0, 1)), 99, 1'b1, 1'b1);
    end
    rdy_mode = 0;

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
